// File: rtl/wash_sequencer_pkg.sv
// Shared encodings for the wash sequencer: phase codes, action codes and
// the per-mode wash/rinse/spin durations in seconds (index = load mode).
package wash_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_WASH  = 3'd1,
        PH_RINSE = 3'd2,
        PH_SPIN  = 3'd3,
        PH_DONE  = 3'd4
    } phase_t;

    localparam logic [3:0] ACT_NONE     = 4'd0;
    localparam logic [3:0] ACT_ROTATE   = 4'd1;
    localparam logic [3:0] ACT_STEW     = 4'd2;
    localparam logic [3:0] ACT_FILL     = 4'd3;
    localparam logic [3:0] ACT_DRAIN    = 4'd4;
    localparam logic [3:0] ACT_FWD_SPIN = 4'd5;
    localparam logic [3:0] ACT_REV_SPIN = 4'd6;
    localparam logic [3:0] ACT_DONE     = 4'd10;

    // Width of the in-phase second counter and of the duration constants.
    localparam int DW = 5;

    localparam logic [DW-1:0] WASH_DUR  [4] = '{5'd0,  5'd10, 5'd15, 5'd20};
    localparam logic [DW-1:0] RINSE_DUR [4] = '{5'd0,  5'd10, 5'd15, 5'd20};
    localparam logic [DW-1:0] SPIN_DUR  [4] = '{5'd15, 5'd10, 5'd15, 5'd20};

    // Length of the given phase for the given load mode.
    function automatic logic [DW-1:0] phase_dur(phase_t ph, logic [1:0] m);
        logic [DW-1:0] d;
        case (ph)
            PH_WASH:  d = WASH_DUR[m];
            PH_RINSE: d = RINSE_DUR[m];
            PH_SPIN:  d = SPIN_DUR[m];
            default:  d = '0;
        endcase
        return d;
    endfunction

    // Action shown to the LEDs for a phase and its elapsed seconds.
    function automatic logic [3:0] action_for(phase_t ph, logic [DW-1:0] s);
        logic [DW-1:0] m3;
        logic [3:0]    a;
        m3 = s % DW'(3);
        case (ph)
            PH_WASH:  a = s[0] ? ACT_STEW : ACT_ROTATE;
            PH_RINSE: begin
                case (m3)
                    DW'(0):  a = ACT_FILL;
                    DW'(1):  a = ACT_ROTATE;
                    default: a = ACT_DRAIN;
                endcase
            end
            PH_SPIN: begin
                case (s[1:0])
                    2'd0:    a = ACT_FWD_SPIN;
                    2'd2:    a = ACT_REV_SPIN;
                    default: a = ACT_DRAIN;
                endcase
            end
            PH_DONE:  a = ACT_DONE;
            default:  a = ACT_NONE;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/wash_sequencer_if.sv
// Panel-to-sequencer-to-display bundle.
// Handshake: start is a one-cycle strobe with no ready; it is taken only on a
// clock edge where on=1 and the sequencer sits in IDLE or DONE, otherwise it
// is dropped. mode/rinse_n are sampled on that same edge. All display
// outputs are registered levels.
interface wash_sequencer_if #(
    parameter int TW           = 8,
    parameter int WATER_LEVELS = 8
);
    logic                    on;
    logic                    start;
    logic [1:0]              mode;
    logic [1:0]              rinse_n;
    logic [2:0]              phase;
    logic [3:0]              action;
    logic [TW-1:0]           remain;
    logic [3:0]              bcd_tens;
    logic [3:0]              bcd_ones;
    logic [WATER_LEVELS-1:0] water;
    logic [1:0]              rinse_idx;
    logic                    done;

    modport master (
        output on, start, mode, rinse_n,
        input  phase, action, remain, bcd_tens, bcd_ones, water, rinse_idx, done
    );

    modport slave (
        input  on, start, mode, rinse_n,
        output phase, action, remain, bcd_tens, bcd_ones, water, rinse_idx, done
    );
endinterface

// File: rtl/wash_sequencer_tick_gen.sv
// wash_tick_gen: one-second prescaler. Emits a tick on the last cycle of a
// second and reports the water level k the prescaler will hold after the
// coming edge, so the top can register water aligned with the prescaler.
module wash_tick_gen #(
    parameter  int TICK_CYCLES  = 100_000_000,
    parameter  int WATER_LEVELS = 8,
    localparam int PW           = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1,
    localparam int KW           = $clog2(WATER_LEVELS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_clr,
    output logic          o_tick,
    output logic [KW-1:0] o_k_next
);
    localparam int STEP = TICK_CYCLES / WATER_LEVELS;

    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_next;
    logic          w_wrap;
    int unsigned   w_k_raw;

    assign w_wrap = (r_presc == PW'(TICK_CYCLES - 1));
    assign o_tick = i_en && !i_clr && w_wrap;

    // Next prescaler value: clear wins, then count with wrap, else hold.
    always_comb begin
        w_presc_next = r_presc;
        if (i_clr)
            w_presc_next = '0;
        else if (i_en)
            w_presc_next = w_wrap ? '0 : r_presc + PW'(1);
    end

    // Water level of the next prescaler value, clamped to the thermometer width.
    always_comb begin
        w_k_raw = 32'(w_presc_next) / 32'(STEP);
        if (w_k_raw > 32'(WATER_LEVELS))
            w_k_raw = 32'(WATER_LEVELS);
    end
    assign o_k_next = KW'(w_k_raw);

    // Prescaler register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_presc <= '0;
        else
            r_presc <= w_presc_next;
    end
endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: wash / N rinse / spin program sequencer with pause and
// restart. Optional feature macro WASH_SEQ_ABORT_EN: when defined, a start
// taken while running aborts straight back to IDLE.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int TICK_CYCLES  = 100_000_000,
    parameter int WATER_LEVELS = 8,
    parameter int TW           = 8
) (
    input  logic            clk,
    input  logic            rst,
    wash_sequencer_if.slave bus
);
    localparam int KW = $clog2(WATER_LEVELS + 1);

    phase_t                  r_phase, w_nxt_phase;
    logic [DW-1:0]           r_s, w_nxt_s;
    logic [TW-1:0]           r_remain, w_nxt_remain;
    logic [1:0]              r_rinse_idx, w_nxt_rinse_idx;
    logic [1:0]              r_mode, r_rinse_n;
    logic [3:0]              r_action, w_nxt_action;
    logic [WATER_LEVELS-1:0] r_water, w_nxt_water;
    logic [3:0]              r_bcd_tens, r_bcd_ones, w_nxt_tens, w_nxt_ones;
    logic                    r_done;
    logic                    w_running, w_start_ok, w_abort, w_tick;
    logic [KW-1:0]           w_k_next, w_fill_n;
    logic [1:0]              w_rn_eff;
    logic [TW-1:0]           w_total;

    assign w_running  = (r_phase == PH_WASH) || (r_phase == PH_RINSE) || (r_phase == PH_SPIN);
    assign w_start_ok = bus.on && bus.start && ((r_phase == PH_IDLE) || (r_phase == PH_DONE));
`ifdef WASH_SEQ_ABORT_EN
    assign w_abort    = bus.on && bus.start && w_running;
`else
    assign w_abort    = 1'b0;
`endif

    // Program length for the mode/rinse count presented with the start strobe.
    assign w_rn_eff = (bus.rinse_n == 2'd0) ? 2'd1 : bus.rinse_n;
    assign w_total  = TW'(WASH_DUR[bus.mode]) + TW'(RINSE_DUR[bus.mode]) * TW'(w_rn_eff)
                    + TW'(SPIN_DUR[bus.mode]);

    wash_tick_gen #(
        .TICK_CYCLES  (TICK_CYCLES),
        .WATER_LEVELS (WATER_LEVELS)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_running && bus.on),
        .i_clr    (w_start_ok || w_abort),
        .o_tick   (w_tick),
        .o_k_next (w_k_next)
    );

    // State register: phase FSM, counters, latched settings and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase     <= PH_IDLE;
            r_s         <= '0;
            r_remain    <= '0;
            r_rinse_idx <= '0;
            r_mode      <= '0;
            r_rinse_n   <= 2'd1;
            r_action    <= ACT_NONE;
            r_water     <= '0;
            r_bcd_tens  <= '0;
            r_bcd_ones  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_phase     <= w_nxt_phase;
            r_s         <= w_nxt_s;
            r_remain    <= w_nxt_remain;
            r_rinse_idx <= w_nxt_rinse_idx;
            r_action    <= w_nxt_action;
            r_water     <= w_nxt_water;
            r_bcd_tens  <= w_nxt_tens;
            r_bcd_ones  <= w_nxt_ones;
            r_done      <= (w_nxt_phase == PH_DONE);
            if (w_start_ok) begin
                r_mode    <= bus.mode;
                r_rinse_n <= w_rn_eff;
            end
        end
    end

    // Next state: start loads a fresh program, abort empties it, a tick
    // advances the second counters and moves on when a phase runs out.
    always_comb begin
        w_nxt_phase     = r_phase;
        w_nxt_s         = r_s;
        w_nxt_remain    = r_remain;
        w_nxt_rinse_idx = r_rinse_idx;
        if (w_start_ok) begin
            w_nxt_s      = '0;
            w_nxt_remain = w_total;
            if (WASH_DUR[bus.mode] != '0)
                w_nxt_phase = PH_WASH;
            else if (RINSE_DUR[bus.mode] != '0)
                w_nxt_phase = PH_RINSE;
            else if (SPIN_DUR[bus.mode] != '0)
                w_nxt_phase = PH_SPIN;
            else
                w_nxt_phase = PH_DONE;
            w_nxt_rinse_idx = (w_nxt_phase == PH_RINSE) ? 2'd1 : 2'd0;
        end else if (w_abort) begin
            w_nxt_phase     = PH_IDLE;
            w_nxt_s         = '0;
            w_nxt_remain    = '0;
            w_nxt_rinse_idx = '0;
        end else if (w_tick) begin
            w_nxt_remain = r_remain - TW'(1);
            if (r_s + DW'(1) == phase_dur(r_phase, r_mode)) begin
                w_nxt_s = '0;
                if (r_phase == PH_WASH && RINSE_DUR[r_mode] != '0) begin
                    w_nxt_phase     = PH_RINSE;
                    w_nxt_rinse_idx = 2'd1;
                end else if (r_phase == PH_RINSE && r_rinse_idx < r_rinse_n) begin
                    w_nxt_rinse_idx = r_rinse_idx + 2'd1;
                end else begin
                    w_nxt_rinse_idx = '0;
                    if (r_phase != PH_SPIN && SPIN_DUR[r_mode] != '0)
                        w_nxt_phase = PH_SPIN;
                    else
                        w_nxt_phase = PH_DONE;
                end
            end else begin
                w_nxt_s = r_s + DW'(1);
            end
        end
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        w_nxt_action = action_for(w_nxt_phase, w_nxt_s);
        w_fill_n     = '0;
        case (w_nxt_phase)
            PH_WASH:  w_fill_n = KW'(WATER_LEVELS);
            PH_RINSE: begin
                if (w_nxt_action == ACT_FILL)
                    w_fill_n = w_k_next;
                else if (w_nxt_action == ACT_DRAIN)
                    w_fill_n = KW'(WATER_LEVELS) - w_k_next;
                else
                    w_fill_n = KW'(WATER_LEVELS);
            end
            default:  w_fill_n = '0;
        endcase
        for (int i = 0; i < WATER_LEVELS; i++)
            w_nxt_water[i] = (i < int'(w_fill_n));
        if (w_nxt_remain > TW'(99)) begin
            w_nxt_tens = 4'd9;
            w_nxt_ones = 4'd9;
        end else begin
            w_nxt_tens = 4'(w_nxt_remain / TW'(10));
            w_nxt_ones = 4'(w_nxt_remain % TW'(10));
        end
    end

    assign bus.phase     = r_phase;
    assign bus.action    = r_action;
    assign bus.remain    = r_remain;
    assign bus.bcd_tens  = r_bcd_tens;
    assign bus.bcd_ones  = r_bcd_ones;
    assign bus.water     = r_water;
    assign bus.rinse_idx = r_rinse_idx;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer with TICK_CYCLES=8, WATER_LEVELS=8, TW=8.
module tb_wash_sequencer;
    localparam int TC = 8;
    localparam int WL = 8;
    localparam int WT [4] = '{0, 10, 15, 20};
    localparam int RT [4] = '{0, 10, 15, 20};
    localparam int ST [4] = '{15, 10, 15, 20};

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    logic [33:0] exp_q[$];
    logic [33:0] obs;

    wash_sequencer_if #(.TW(8), .WATER_LEVELS(WL)) bus();

    wash_sequencer #(.TICK_CYCLES(TC), .WATER_LEVELS(WL), .TW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {bus.phase, bus.action, bus.remain, bus.bcd_tens, bus.bcd_ones,
                  bus.water, bus.rinse_idx, bus.done};

    function automatic logic [7:0] therm(input int n);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < WL; i++) v[i] = (i < n);
        return v;
    endfunction

    function automatic int prog_total(input int m, input int rn);
        return WT[m] + RT[m] * ((rn == 0) ? 1 : rn) + ST[m];
    endfunction

    // Expected outputs t seconds into a program, sampled with prescaler at 0.
    function automatic logic [33:0] exp_snap(input int m, input int rn, input int t);
        int rr, tot, ph, ss, idx, rem;
        logic [3:0] act;
        logic [7:0] wat;
        rr  = (rn == 0) ? 1 : rn;
        tot = prog_total(m, rn);
        rem = tot - t;
        idx = 0;
        ss  = 0;
        if (t >= tot) ph = 4;
        else if (t < WT[m]) begin ph = 1; ss = t; end
        else if (t < WT[m] + RT[m] * rr) begin
            ph = 2; idx = (t - WT[m]) / RT[m] + 1; ss = (t - WT[m]) % RT[m];
        end else begin ph = 3; ss = t - WT[m] - RT[m] * rr; end
        act = 4'd0;
        wat = 8'h00;
        case (ph)
            1: begin act = (ss % 2 == 0) ? 4'd1 : 4'd2; wat = 8'hFF; end
            2: begin
                case (ss % 3)
                    0: begin act = 4'd3; wat = therm(0); end
                    1: begin act = 4'd1; wat = 8'hFF; end
                    default: begin act = 4'd4; wat = therm(WL); end
                endcase
            end
            3: begin
                case (ss % 4)
                    0: act = 4'd5;
                    2: act = 4'd6;
                    default: act = 4'd4;
                endcase
            end
            4: act = 4'd10;
            default: act = 4'd0;
        endcase
        return {3'(ph), act, 8'(rem), (rem > 99) ? 4'd9 : 4'(rem / 10),
                (rem > 99) ? 4'd9 : 4'(rem % 10), wat, 2'(idx), (ph == 4)};
    endfunction

    // Driver tasks (called at a falling edge, return at a falling edge)
    task automatic pulse_start(input logic [1:0] m, input logic [1:0] rn);
        bus.mode    = m;
        bus.rinse_n = rn;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.on = 1'b1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [33:0] e;
        rst = 1'b0;
        bus.on = 1'b1; bus.start = 1'b0; bus.mode = 2'd0; bus.rinse_n = 2'd0;
        repeat (2) @(negedge clk);
        n_total++;
        if (obs !== 34'd0) begin
            $display("FAIL reset_por: got %h want %h", obs, 34'd0); n_bad++;
        end
        rst = 1'b1;
        @(negedge clk);
        e = exp_snap(1, 1, 25);
        exp_q.push_back(e);
        pulse_start(2'd1, 2'd1);
        repeat (25 * TC) @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) begin
            $display("FAIL reset_pre_spin: got %h want %h", obs, e); n_bad++;
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_total++;
        if (obs !== 34'd0) begin
            $display("FAIL reset_mid_spin: got %h want %h", obs, 34'd0); n_bad++;
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_full_run(input logic [1:0] m, input logic [1:0] rn);
        int tot;
        logic [33:0] e;
        tot = prog_total(int'(m), int'(rn));
        for (int t = 0; t <= tot; t++) exp_q.push_back(exp_snap(int'(m), int'(rn), t));
        pulse_start(m, rn);
        bus.mode    = 2'($urandom_range(0, 3));
        bus.rinse_n = 2'($urandom_range(0, 3));
        for (int t = 0; t <= tot; t++) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) begin
                $display("FAIL run m%0d r%0d t%0d: got %h want %h", m, rn, t, obs, e);
                n_bad++;
            end
            if (t < tot) repeat (TC) @(negedge clk);
        end
    endtask

    task automatic test_restart();
        logic [33:0] e;
        e = exp_snap(1, 2, 40);
        exp_q.push_back(e);
        bus.on = 1'b0;
        pulse_start(2'd3, 2'd3);
        @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) begin
            $display("FAIL start_while_off: got %h want %h", obs, e); n_bad++;
        end
        bus.on = 1'b1;
        test_full_run(2'd0, 2'd0);
    endtask

    task automatic test_pause();
        logic [33:0] e;
        do_reset();
        pulse_start(2'd1, 2'd1);
        repeat (3 * TC + 3) @(negedge clk);
        exp_q.push_back(exp_snap(1, 1, 3));
        exp_q.push_back(exp_snap(1, 1, 3));
        exp_q.push_back(exp_snap(1, 1, 4));
        bus.on = 1'b0;
        repeat (20) @(negedge clk);
        pulse_start(2'd0, 2'd0);
        repeat (29) @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) begin $display("FAIL pause_hold: got %h want %h", obs, e); n_bad++; end
        bus.on = 1'b1;
        repeat (4) @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) begin $display("FAIL resume_early: got %h want %h", obs, e); n_bad++; end
        @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) begin $display("FAIL resume_tick: got %h want %h", obs, e); n_bad++; end
    endtask

    task automatic test_water();
        logic [7:0] ew;
        do_reset();
        pulse_start(2'd1, 2'd1);
        repeat (10 * TC) @(negedge clk);
        for (int c = 0; c < TC; c++) exp_q.push_back({26'd0, therm(c)});
        for (int c = 0; c < TC; c++) exp_q.push_back({26'd0, therm(WL - c)});
        for (int c = 0; c < TC; c++) begin
            ew = 8'(exp_q.pop_front());
            n_total++;
            if (bus.water !== ew) begin
                $display("FAIL water_fill c%0d: got %h want %h", c, bus.water, ew); n_bad++;
            end
            @(negedge clk);
        end
        repeat (TC) @(negedge clk);
        for (int c = 0; c < TC; c++) begin
            ew = 8'(exp_q.pop_front());
            n_total++;
            if (bus.water !== ew) begin
                $display("FAIL water_drain c%0d: got %h want %h", c, bus.water, ew); n_bad++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_running();
        logic [33:0] e;
        do_reset();
        pulse_start(2'd1, 2'd1);
        repeat (12 * TC + 3) @(negedge clk);
`ifdef WASH_SEQ_ABORT_EN
        exp_q.push_back(34'd0);
        exp_q.push_back(34'd0);
`else
        e = exp_snap(1, 1, 12);
        e[10:3] = 8'h0F;
        exp_q.push_back(e);
        exp_q.push_back(exp_snap(1, 1, 13));
`endif
        pulse_start(2'd0, 2'd3);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) begin $display("FAIL start_in_rinse: got %h want %h", obs, e); n_bad++; end
        repeat (4) @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) begin $display("FAIL after_start_in_rinse: got %h want %h", obs, e); n_bad++; end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_full_run(2'd1, 2'd2);
        test_restart();
        test_full_run(2'd3, 2'd3);
        test_full_run(2'd2, 2'd0);
        test_pause();
        test_water();
        test_start_running();
        do_reset();
        test_full_run(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Parametrised second-generation washing-machine program sequencer. Runs a wash, N rinse cycles and spin phase per selected load mode, with pause/resume, restart after completion, and optional abort. Drives phase/action codes, remaining-time counters (binary and BCD) and a water-level thermometer to the board display and LED logic. Sits between the panel switches/debounced start button and the 4-digit scanner.

## Interface
- TICK_CYCLES, 100_000_000, clk cycles per 1 s tick; must be a multiple of WATER_LEVELS and ≥ WATER_LEVELS
- WATER_LEVELS, 8, width of water-level thermometer
- TW, 8, width of the remaining-seconds counter (≥ 7)
- clk  in  1  system clock
- rst  in  1  reset: one clock; reset is asynchronous and active-low
- on  in  1  run enable; low = pause (everything frozen)
- start  in  1  single-cycle start pulse (debounced upstream)
- mode  in  2  00 spin-only, 01 small, 10 medium, 11 large; sampled on accepted start
- rinse_n  in  2  rinse cycles 1..3 (0 treated as 1); sampled on accepted start
- phase  out  3  IDLE=0, WASH=1, RINSE=2, SPIN=3, DONE=4
- action  out  4  0 none, 1 rotate, 2 stew, 3 add water, 4 drain, 5 forward spin, 6 reverse spin, 10 finished
- remain  out  TW  seconds remaining
- bcd_tens, bcd_ones  out  4 each  BCD of remain (remain ≤ 99 displayed; 100+ shows 9,9)
- water  out  WATER_LEVELS  thermometer, bit 0 = lowest
- rinse_idx  out  2  current rinse cycle, 1-based; 0 outside RINSE
- done  out  1  level, high in DONE

## Operation
- Durations (s) W/R/S per mode: 00 → 0/0/15; 01 → 10/10/10; 10 → 15/15/15; 11 → 20/20/20. R is per rinse cycle. Total = W + R·rinse_n + S (mode 00: 15). Zero-length phases skipped.
- Accepted start: on=1, start=1, phase ∈ {IDLE, DONE}. Latches mode/rinse_n, loads remain = total, clears prescaler and phase-second counter s, enters first non-empty phase; done clears.
- Tick: prescaler reaches TICK_CYCLES-1 while on=1 and phase ∈ {WASH, RINSE, SPIN}; prescaler → 0, remain −1, s +1.
- When s reaches the phase duration on a tick: s → 0; WASH→RINSE(idx 1); RINSE idx<rinse_n → idx+1 else → SPIN; SPIN → DONE.
- Actions by s: WASH even → 1, odd → 2; RINSE s mod 3: 0 → 3, 1 → 1, 2 → 4; SPIN s mod 4: 0 → 5, 1 → 4, 2 → 6, 3 → 4; IDLE → 0; DONE → 10.
- Water: k = min(prescaler / (TICK_CYCLES/WATER_LEVELS), WATER_LEVELS). Add water: k low bits set. Drain in RINSE: WATER_LEVELS−k bits set. Rotate in RINSE and all of WASH: all ones. SPIN, IDLE, DONE: all zero.
- on=0: prescaler, s, remain, phase frozen; outputs hold. Start while on=0 ignored.
- Start while running ignored (see Configuration).

## Timing
- Reset: phase IDLE, action 0, remain 0, bcd 0/0, water 0, rinse_idx 0, done 0, prescaler 0.
- All outputs registered. Accepted start at edge n → phase/remain valid after edge n.
- First tick TICK_CYCLES cycles after start edge; remain, s, phase, action, done update on the same edge.
- remain reaches 0 on the same edge as SPIN → DONE.
- BCD updates same edge as remain (combinational conversion into registers).
- Reset mid-run: immediate return to reset values, no drain sequence.

## Configuration
- WASH_SEQ_ABORT_EN defined: start with on=1 in WASH/RINSE/SPIN aborts to IDLE next edge; remain 0, water 0, done 0.
- Undefined: start ignored outside IDLE/DONE.

## Structure
- Package wash_pkg: phase and action encodings, per-mode W/R/S constant arrays, DONE action code 10.
- Sub-module wash_tick_gen: prescaler with enable and clear, outputs tick pulse and water level k.
- Top holds phase FSM, s/remain/rinse_idx counters, action/water decode, BCD conversion.

## Test plan
TICK_CYCLES=8, WATER_LEVELS=8 in bench.
- Reset low mid-SPIN → all outputs at reset values immediately; start after release begins a fresh run.
- mode 01, rinse_n 2, start → remain 40; WASH 10 ticks alternating 1/2; RINSE idx 1,2 each 10 ticks with 3,1,4 pattern; SPIN 10 ticks; done=1, action 10, remain 0 at tick 40.
- mode 00 → phase SPIN directly, remain 15, bcd 1/5; DONE after 15 ticks.
- on low for 50 cycles mid-WASH → remain, prescaler, action unchanged; resumes with exact remaining cycle count.
- RINSE add-water second → water 0x00,0x01,0x03…0x7F on consecutive cycles; drain second → 0xFF,0x7F…0x01.
- Start during RINSE: without WASH_SEQ_ABORT_EN no effect; with it → IDLE next edge, water 0; start from DONE restarts with remain = new total.
